opcode_fetch_unit: RTL and testbench

- Producer side of the instruction register.
- Sequences 6502 instruction fetch: reads the opcode byte at PC from memory, presents it on OUT_OPCODE, and pulses load_IR so the instruction register captures it.
- After the decoder reports instruction length, reads 0–2 operand bytes and issues the complete instruction to the execute FSM with a valid/ack handshake.
- Owns the program counter, including wrap and jump redirect.

---
 rtl/opcode_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_opcode_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_fetch_unit.sv
// 6502 instruction fetch sequencer: reads opcode and 0-2 operand bytes, loads the IR,
// and issues the complete instruction to the execute FSM over a valid/ack handshake.
module opcode_fetch_unit #(
    parameter int unsigned            ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(16'h0200)
) (
    input  logic              FSM_Signal,
    input  logic              reset_FETCH,
    input  logic              run_FETCH,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              mem_rd,
    input  logic [7:0]        MEM_DATA,
    input  logic              mem_ready,
    output logic [7:0]        OUT_OPCODE,
    output logic              load_IR,
    input  logic [1:0]        LEN_IN,
    output logic [15:0]       OUT_OPERAND,
    output logic [ADDR_W-1:0] OUT_PC,
    output logic              instr_valid,
    input  logic              exec_ack,
    input  logic              load_PC,
    input  logic [ADDR_W-1:0] PC_IN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_LD,
        S_LEN,
        S_LO,
        S_HI,
        S_ISSUE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
    logic [ADDR_W-1:0]   out_pc_d;
    logic [7:0]          opcode_d;
    logic [15:0]         operand_d;
    logic [1:0]          len_q, len_d;
    logic                mem_rd_d, load_ir_d, instr_valid_d;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign MEM_ADDR = pc_q;

    // State register
    always_ff @(posedge FSM_Signal or posedge reset_FETCH) begin
        if (reset_FETCH) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        out_pc_d  = OUT_PC;
        opcode_d  = OUT_OPCODE;
        operand_d = OUT_OPERAND;
        len_d     = len_q;

        case (state_q)
            S_IDLE: begin
                if (run_FETCH) begin
                    state_d   = S_OP;
                    operand_d = 16'h0000;
                    out_pc_d  = pc_q;
                end
            end
            S_OP: begin
                if (mem_ready) begin
                    opcode_d = MEM_DATA;
                    pc_d     = pc_inc;
                    state_d  = S_LD;
                end
            end
            S_LD: begin
                state_d = S_LEN;
            end
            S_LEN: begin
                // A zero length from the decoder is treated as a one-byte instruction
                len_d   = (LEN_IN == 2'd0) ? 2'd1 : LEN_IN;
                state_d = LEN_IN[1] ? S_LO : S_ISSUE;
            end
            S_LO: begin
                if (mem_ready) begin
                    operand_d[7:0] = MEM_DATA;
                    pc_d           = pc_inc;
                    state_d        = (len_q == 2'd3) ? S_HI : S_ISSUE;
                end
            end
            S_HI: begin
                if (mem_ready) begin
                    operand_d[15:8] = MEM_DATA;
                    pc_d            = pc_inc;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (exec_ack) begin
                    if (load_PC) begin
                        pc_d = PC_IN;
                    end
                    if (run_FETCH) begin
                        state_d   = S_OP;
                        operand_d = 16'h0000;
                        out_pc_d  = pc_d;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_rd_d      = (state_d == S_OP) || (state_d == S_LO) || (state_d == S_HI);
        load_ir_d     = (state_d == S_LD);
        instr_valid_d = (state_d == S_ISSUE);
    end

    // Datapath and registered outputs
    always_ff @(posedge FSM_Signal or posedge reset_FETCH) begin
        if (reset_FETCH) begin
            pc_q        <= RESET_PC;
            len_q       <= 2'd1;
            OUT_OPCODE  <= 8'h00;
            OUT_OPERAND <= 16'h0000;
            OUT_PC      <= '0;
            mem_rd      <= 1'b0;
            load_IR     <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            len_q       <= len_d;
            OUT_OPCODE  <= opcode_d;
            OUT_OPERAND <= operand_d;
            OUT_PC      <= out_pc_d;
            mem_rd      <= mem_rd_d;
            load_IR     <= load_ir_d;
            instr_valid <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_opcode_fetch_unit.sv
// Self-checking bench for opcode_fetch_unit: instruction-level model queue plus
// directed scenarios with hand-computed expectations.
module tb_opcode_fetch_unit;

    logic        FSM_Signal = 1'b0;
    logic        reset_FETCH;
    logic        run_FETCH;
    logic [15:0] MEM_ADDR;
    logic        mem_rd;
    logic [7:0]  MEM_DATA;
    logic        mem_ready;
    logic [7:0]  OUT_OPCODE;
    logic        load_IR;
    logic [1:0]  LEN_IN;
    logic [15:0] OUT_OPERAND;
    logic [15:0] OUT_PC;
    logic        instr_valid;
    logic        exec_ack;
    logic        load_PC;
    logic [15:0] PC_IN;

    opcode_fetch_unit dut (
        .FSM_Signal  (FSM_Signal),
        .reset_FETCH (reset_FETCH),
        .run_FETCH   (run_FETCH),
        .MEM_ADDR    (MEM_ADDR),
        .mem_rd      (mem_rd),
        .MEM_DATA    (MEM_DATA),
        .mem_ready   (mem_ready),
        .OUT_OPCODE  (OUT_OPCODE),
        .load_IR     (load_IR),
        .LEN_IN      (LEN_IN),
        .OUT_OPERAND (OUT_OPERAND),
        .OUT_PC      (OUT_PC),
        .instr_valid (instr_valid),
        .exec_ack    (exec_ack),
        .load_PC     (load_PC),
        .PC_IN       (PC_IN)
    );

    always #5 FSM_Signal = ~FSM_Signal;

    typedef struct {
        logic [7:0]  opcode;
        logic [15:0] operand;
        logic [15:0] pc;
        int          len;
        bit          jmp;
        bit          stray;
        logic [15:0] tgt;
    } exp_t;

    logic [7:0]  mem [0:65535];
    exp_t        q[$];
    logic [15:0] model_pc;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    int          ack_delay = 0;
    int          vcnt = 0;
    logic [15:0] stall_addr = 16'h0000;
    int          stall_left = 0;

    // Decoder stand-in: raw length reported for an opcode
    function automatic logic [1:0] len_raw(input logic [7:0] op);
        case (op)
            8'hA9:        return 2'd2;
            8'hAD, 8'h4C: return 2'd3;
            8'h02:        return 2'd0;
            default:      return 2'd1;
        endcase
    endfunction

    assign LEN_IN   = len_raw(OUT_OPCODE);
    assign MEM_DATA = mem[MEM_ADDR];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the next instruction in program order from model_pc
    task automatic push_instr(input bit jmp, input bit stray, input logic [15:0] tgt);
        exp_t e;
        int   l;
        e.opcode  = mem[model_pc];
        l         = (len_raw(e.opcode) == 2'd0) ? 1 : int'(len_raw(e.opcode));
        e.pc      = model_pc;
        e.len     = l;
        e.operand = 16'h0000;
        if (l >= 2) e.operand[7:0]  = mem[16'(model_pc + 16'd1)];
        if (l == 3) e.operand[15:8] = mem[16'(model_pc + 16'd2)];
        e.jmp   = jmp;
        e.stray = stray;
        e.tgt   = tgt;
        model_pc = jmp ? tgt : 16'(model_pc + 16'(l));
        q.push_back(e);
    endtask

    // Memory responder: optional wait cycles on one address
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge FSM_Signal);
            #1;
            if (mem_rd && MEM_ADDR == stall_addr && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // Execute-side responder: ack after ack_delay cycles, jump/stray load_PC from the model
    initial begin
        exec_ack = 1'b0;
        load_PC  = 1'b0;
        PC_IN    = 16'h0000;
        forever begin
            @(posedge FSM_Signal);
            #1;
            if (instr_valid) begin
                exec_ack = (vcnt >= ack_delay);
                vcnt++;
            end else begin
                exec_ack = 1'b0;
                vcnt     = 0;
            end
            if (q.size() > 0) begin
                load_PC = q[0].jmp || (q[0].stray && !instr_valid);
                PC_IN   = q[0].tgt;
            end else begin
                load_PC = 1'b0;
                PC_IN   = 16'h0000;
            end
        end
    end

    // Per-cycle comparison against the model queue
    initial begin
        forever begin
            @(negedge FSM_Signal);
            if (chk_en) begin
                if (instr_valid) begin
                    if (q.size() == 0) begin
                        chk1("unexpected_issue", instr_valid, 1'b0);
                    end else begin
                        chk16("issue_opcode", 16'(OUT_OPCODE), 16'(q[0].opcode));
                        chk16("issue_operand", OUT_OPERAND, q[0].operand);
                        chk16("issue_pc", OUT_PC, q[0].pc);
                        if (exec_ack) void'(q.pop_front());
                    end
                end
                if (mem_rd && q.size() > 0)
                    chk1("fetch_addr_in_instr", 16'(MEM_ADDR - q[0].pc) < 16'(q[0].len), 1'b1);
                if (load_IR && q.size() > 0)
                    chk16("ir_opcode", 16'(OUT_OPCODE), 16'(q[0].opcode));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        chk_en      = 1'b0;
        run_FETCH   = 1'b0;
        reset_FETCH = 1'b1;
        #1;
        chk1("rst_mem_rd", mem_rd, 1'b0);
        chk1("rst_load_ir", load_IR, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk16("rst_opcode", 16'(OUT_OPCODE), 16'h0000);
        chk16("rst_operand", OUT_OPERAND, 16'h0000);
        chk16("rst_out_pc", OUT_PC, 16'h0000);
        chk16("rst_mem_addr", MEM_ADDR, 16'h0200);
        repeat (2) @(negedge FSM_Signal);
        q.delete();
        stall_left = 0;
        ack_delay  = 0;
        model_pc   = 16'h0200;
    endtask

    task automatic release_run();
        reset_FETCH = 1'b0;
        run_FETCH   = 1'b1;
        chk_en      = 1'b1;
    endtask

    // sel=1: wait for instr_valid, sel=0: wait for mem_rd
    task automatic wait_sig(input string name, input bit sel);
        int n = 0;
        @(negedge FSM_Signal);
        while (!(sel ? instr_valid : mem_rd) && n < 40) begin
            @(negedge FSM_Signal);
            n++;
        end
        chk1({name, "_seen"}, sel ? instr_valid : mem_rd, 1'b1);
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int n = 0;
        @(negedge FSM_Signal);
        while (!(mem_rd && MEM_ADDR == a) && n < 40) begin
            @(negedge FSM_Signal);
            n++;
        end
        chk16("wait_addr_reached", MEM_ADDR, a);
    endtask

    initial begin
        reset_FETCH = 1'b1;
        run_FETCH   = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // One-byte instruction, zero-wait memory, immediate ack
        apply_reset();
        mem[16'h0200] = 8'hEA;
        push_instr(1'b0, 1'b0, 16'h0000);
        release_run();
        @(negedge FSM_Signal);
        chk1("a_c0_mem_rd", mem_rd, 1'b1);
        chk16("a_c0_addr", MEM_ADDR, 16'h0200);
        run_FETCH = 1'b0;
        @(negedge FSM_Signal);
        chk1("a_c1_load_ir", load_IR, 1'b1);
        chk16("a_c1_opcode", 16'(OUT_OPCODE), 16'h00EA);
        @(negedge FSM_Signal);
        chk1("a_c2_valid", instr_valid, 1'b0);
        @(negedge FSM_Signal);
        chk1("a_c3_valid", instr_valid, 1'b1);
        chk16("a_c3_out_pc", OUT_PC, 16'h0200);
        chk16("a_c3_operand", OUT_OPERAND, 16'h0000);
        chk16("a_c3_pc", MEM_ADDR, 16'h0201);
        repeat (2) @(negedge FSM_Signal);
        chk1("a_idle_mem_rd", mem_rd, 1'b0);
        chk16("a_idle_addr", MEM_ADDR, 16'h0201);
        chk16("a_drained", 16'(q.size()), 16'h0000);

        // Three wait cycles on the opcode read
        apply_reset();
        stall_addr = 16'h0200;
        stall_left = 3;
        push_instr(1'b0, 1'b0, 16'h0000);
        release_run();
        for (int i = 0; i < 4; i++) begin
            @(negedge FSM_Signal);
            chk1("b_wait_mem_rd", mem_rd, 1'b1);
            chk16("b_wait_addr", MEM_ADDR, 16'h0200);
            chk1("b_wait_no_load_ir", load_IR, 1'b0);
        end
        run_FETCH = 1'b0;
        @(negedge FSM_Signal);
        chk1("b_c4_load_ir", load_IR, 1'b1);
        @(negedge FSM_Signal);
        chk1("b_c5_valid", instr_valid, 1'b0);
        @(negedge FSM_Signal);
        chk1("b_c6_valid", instr_valid, 1'b1);
        repeat (3) @(negedge FSM_Signal);
        chk1("b_idle_mem_rd", mem_rd, 1'b0);
        chk16("b_drained", 16'(q.size()), 16'h0000);

        // Late ack, jumps, stray load_PC, zero length, PC wrap
        apply_reset();
        mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
        mem[16'h0203] = 8'h4C; mem[16'h0204] = 8'h00; mem[16'h0205] = 8'hC0;
        mem[16'hC000] = 8'h02;
        mem[16'hC001] = 8'h4C; mem[16'hC002] = 8'hFE; mem[16'hC003] = 8'hFF;
        mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h55;
        mem[16'h0000] = 8'hEA;
        ack_delay = 2;
        push_instr(1'b0, 1'b0, 16'h0000);
        push_instr(1'b1, 1'b0, 16'hC000);
        push_instr(1'b0, 1'b1, 16'h1111);
        push_instr(1'b1, 1'b0, 16'hFFFE);
        push_instr(1'b0, 1'b0, 16'h0000);
        push_instr(1'b0, 1'b0, 16'h0000);
        release_run();
        wait_sig("c_lda_valid", 1'b1);
        chk16("c_lda_opcode", 16'(OUT_OPCODE), 16'h00AD);
        chk16("c_lda_operand", OUT_OPERAND, 16'h1234);
        chk16("c_lda_out_pc", OUT_PC, 16'h0200);
        @(negedge FSM_Signal);
        chk1("c_lda_hold_valid", instr_valid, 1'b1);
        chk16("c_lda_hold_operand", OUT_OPERAND, 16'h1234);
        wait_sig("c_next_rd", 1'b0);
        chk16("c_next_fetch", MEM_ADDR, 16'h0203);
        wait_sig("c_jmp1_valid", 1'b1);
        wait_sig("c_jmp1_rd", 1'b0);
        chk16("c_jump_c000", MEM_ADDR, 16'hC000);
        wait_sig("c_len0_valid", 1'b1);
        chk16("c_len0_out_pc", OUT_PC, 16'hC000);
        chk16("c_len0_operand", OUT_OPERAND, 16'h0000);
        wait_sig("c_len0_rd", 1'b0);
        chk16("c_stray_ignored", MEM_ADDR, 16'hC001);
        wait_sig("c_jmp2_valid", 1'b1);
        wait_sig("c_jmp2_rd", 1'b0);
        chk16("c_jump_fffe", MEM_ADDR, 16'hFFFE);
        wait_sig("c_wrap_valid", 1'b1);
        chk16("c_wrap_operand", OUT_OPERAND, 16'h0055);
        chk16("c_wrap_out_pc", OUT_PC, 16'hFFFE);
        wait_sig("c_wrap_rd", 1'b0);
        chk16("c_wrap_fetch", MEM_ADDR, 16'h0000);
        run_FETCH = 1'b0;
        wait_sig("c_last_valid", 1'b1);
        chk16("c_last_out_pc", OUT_PC, 16'h0000);
        repeat (4) @(negedge FSM_Signal);
        chk1("c_idle_mem_rd", mem_rd, 1'b0);
        chk1("c_idle_valid", instr_valid, 1'b0);
        chk16("c_idle_addr", MEM_ADDR, 16'h0001);
        chk16("c_drained", 16'(q.size()), 16'h0000);

        // run_FETCH dropped during the low operand read
        apply_reset();
        mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h78; mem[16'h0202] = 8'h56;
        push_instr(1'b0, 1'b0, 16'h0000);
        release_run();
        wait_addr(16'h0201);
        run_FETCH = 1'b0;
        wait_sig("d_valid", 1'b1);
        chk16("d_operand", OUT_OPERAND, 16'h5678);
        chk16("d_out_pc", OUT_PC, 16'h0200);
        repeat (3) @(negedge FSM_Signal);
        chk1("d_idle_mem_rd", mem_rd, 1'b0);
        chk1("d_idle_valid", instr_valid, 1'b0);
        chk16("d_idle_addr", MEM_ADDR, 16'h0203);

        // Asynchronous reset during a stalled high operand read
        apply_reset();
        stall_addr = 16'h0202;
        stall_left = 5;
        push_instr(1'b0, 1'b0, 16'h0000);
        release_run();
        wait_addr(16'h0202);
        @(negedge FSM_Signal);
        chk1("e_in_hi_wait", mem_rd, 1'b1);
        chk_en      = 1'b0;
        reset_FETCH = 1'b1;
        #1;
        chk1("e_async_mem_rd", mem_rd, 1'b0);
        chk1("e_async_valid", instr_valid, 1'b0);
        chk16("e_async_addr", MEM_ADDR, 16'h0200);
        chk16("e_async_operand", OUT_OPERAND, 16'h0000);
        chk16("e_async_opcode", 16'(OUT_OPCODE), 16'h0000);
        repeat (2) @(negedge FSM_Signal);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
